// File: rtl/modinv_64.sv
// rtl/modinv_64.sv - 64-bit modular inverse d = e^-1 mod m by extended Euclid with a bit-serial divider
module modinv_64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ina,
    input  logic [63:0] inb,
    output logic [63:0] result,
    output logic        ready_n,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, LOAD, DIV, UPD, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [63:0]        m_q, m_d;
    logic [63:0]        r0_q, r0_d;
    logic [63:0]        r1_q, r1_d;
    logic [63:0]        rem_q, rem_d;
    logic [63:0]        d_q, d_d;
    logic [5:0]         cnt_q, cnt_d;
    logic signed [65:0] t0_q, t0_d;
    logic signed [65:0] t1_q, t1_d;
    logic signed [65:0] acc_q, acc_d;
    logic [63:0]        result_q, result_d;
    logic               err_q, err_d;
    logic               ready_n_q, ready_n_d;

    logic [63:0] div_num, div_den, div_start;
    logic [6:0]  len_num, len_den;
    logic [5:0]  div_shift;
    logic        sub_ok;

    function automatic logic [6:0] bit_len(input logic [63:0] v);
        logic [6:0] n;
        n = 7'd0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) n = 7'(i + 1);
        end
        return n;
    endfunction

    // The divisor is pre-aligned to the dividend's top bit so a quotient costs
    // only (len(num) - len(den) + 1) steps instead of a fixed 64.
    always_comb begin
        div_num   = (state_q == LOAD) ? r0_q : r1_q;
        div_den   = (state_q == LOAD) ? r1_q : rem_q;
        len_num   = bit_len(div_num);
        len_den   = bit_len(div_den);
        div_shift = (len_num > len_den) ? 6'(len_num - len_den) : 6'd0;
        div_start = div_den << div_shift;
        sub_ok    = (rem_q >= d_q);
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        r0_d      = r0_q;
        r1_d      = r1_q;
        rem_d     = rem_q;
        d_d       = d_q;
        cnt_d     = cnt_q;
        t0_d      = t0_q;
        t1_d      = t1_q;
        acc_d     = acc_q;
        result_d  = result_q;
        err_d     = err_q;
        ready_n_d = ready_n_q;
        case (state_q)
            IDLE: begin
                m_d     = inb;
                r0_d    = inb;
                r1_d    = {32'd0, ina};
                t0_d    = 66'sd0;
                t1_d    = 66'sd1;
                state_d = LOAD;
            end
            LOAD: begin
                if (m_q < 64'd2 || r1_q == 64'd0) begin
                    state_d = FIX;
                end else begin
                    rem_d   = div_num;
                    d_d     = div_start;
                    cnt_d   = div_shift;
                    acc_d   = 66'sd0;
                    state_d = DIV;
                end
            end
            DIV: begin
                // acc accumulates q*t1 in Horner form as quotient bits appear.
                if (sub_ok) rem_d = rem_q - d_q;
                acc_d = (acc_q <<< 1) + (sub_ok ? t1_q : 66'sd0);
                d_d   = d_q >> 1;
                if (cnt_q == 6'd0) state_d = UPD;
                else               cnt_d   = cnt_q - 6'd1;
            end
            UPD: begin
                r0_d = r1_q;
                r1_d = rem_q;
                t0_d = t1_q;
                t1_d = t0_q - acc_q;
                if (rem_q == 64'd0) begin
                    state_d = FIX;
                end else begin
                    rem_d   = div_num;
                    d_d     = div_start;
                    cnt_d   = div_shift;
                    acc_d   = 66'sd0;
                    state_d = DIV;
                end
            end
            FIX: begin
                if (r0_q == 64'd1 && m_q >= 64'd2) begin
                    result_d = t0_q[65] ? (t0_q[63:0] + m_q) : t0_q[63:0];
                    err_d    = 1'b0;
                end else begin
                    result_d = 64'd0;
                    err_d    = 1'b1;
                end
                ready_n_d = 1'b0;
                state_d   = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= 64'd0;
            r0_q      <= 64'd0;
            r1_q      <= 64'd0;
            rem_q     <= 64'd0;
            d_q       <= 64'd0;
            cnt_q     <= 6'd0;
            t0_q      <= 66'sd0;
            t1_q      <= 66'sd0;
            acc_q     <= 66'sd0;
            result_q  <= 64'd0;
            err_q     <= 1'b0;
            ready_n_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            r0_q      <= r0_d;
            r1_q      <= r1_d;
            rem_q     <= rem_d;
            d_q       <= d_d;
            cnt_q     <= cnt_d;
            t0_q      <= t0_d;
            t1_q      <= t1_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            err_q     <= err_d;
            ready_n_q <= ready_n_d;
        end
    end

    assign result  = result_q;
    assign err     = err_q;
    assign ready_n = ready_n_q;

endmodule
